// File: rtl/sopc_2_cpu_jtag_mon_access_if.sv
// Debug-RAM bus between the JTAG monitor access engine (master) and the CPU's debug RAM port (slave).
interface sopc_2_cpu_jtag_mon_access_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_waitrequest
  );
endinterface

// File: rtl/sopc_2_cpu_jtag_mon_access.sv
// Nios II JTAG debug-monitor engine: turns ocimem strobes into single-word
// debug-RAM reads/writes, with wait-state timeout and overrun reporting.
module sopc_2_cpu_jtag_mon_access #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  sopc_2_cpu_jtag_mon_access_if.master bus,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic                read_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic                any_strobe;
  logic                last_wait;
  logic                unused_jdo;

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign last_wait  = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign bus.mem_address   = addr_q;
  assign bus.mem_read      = read_q;
  assign bus.mem_write     = write_q;
  assign bus.mem_writedata = wdata_q;

  // Command decode in IDLE; access/timeout handling while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_action_ocimem_a) begin
            addr_q        <= jdo[17 +: ADDR_W];
            monitor_error <= 1'b0;
            if (jdo[34]) begin
              state         <= RD;
              read_q        <= 1'b1;
              monitor_ready <= 1'b0;
              wait_cnt      <= '0;
            end
          end else if (take_no_action_ocimem_a) begin
            state         <= RD;
            read_q        <= 1'b1;
            monitor_ready <= 1'b0;
            wait_cnt      <= '0;
          end else if (take_action_ocimem_b) begin
            wdata_q       <= jdo[34:3];
            MonDReg       <= jdo[34:3];
            state         <= WR;
            write_q       <= 1'b1;
            monitor_ready <= 1'b0;
            wait_cnt      <= '0;
          end
        end

        RD, WR: begin
          if (any_strobe) begin
            monitor_error <= 1'b1;
          end
          if (!bus.mem_waitrequest) begin
            if (state == RD) begin
              MonDReg <= bus.mem_readdata;
            end
            addr_q        <= addr_q + ADDR_W'(1);
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            monitor_ready <= 1'b1;
            state         <= IDLE;
          end else if (last_wait) begin
            // Abort: address and MonDReg are left as they were.
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: begin
          state         <= IDLE;
          read_q        <= 1'b0;
          write_q       <= 1'b0;
          monitor_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_2_cpu_jtag_mon_access.sv
// Directed plus randomized check of the JTAG monitor access engine against a
// transaction-level model of address, MonDReg, error flag and RAM contents.
module tb_sopc_2_cpu_jtag_mon_access;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 4;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_a;
  logic        take_na;
  logic        take_b;
  logic [31:0] mon_dreg;
  logic        mon_ready;
  logic        mon_error;

  sopc_2_cpu_jtag_mon_access_if #(.ADDR_W(ADDR_W)) bus ();

  sopc_2_cpu_jtag_mon_access #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_na),
    .take_action_ocimem_b    (take_b),
    .bus                     (bus.master),
    .MonDReg                 (mon_dreg),
    .monitor_ready           (mon_ready),
    .monitor_error           (mon_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Slave RAM (written by the DUT) and the model's expected RAM.
  logic [31:0] ram   [256];
  logic [31:0] m_ram [256];
  logic [7:0]  m_addr;
  logic [31:0] m_dreg;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 0 ocimem_a, 1 no_action_ocimem_a, 2 ocimem_b, 3 ocimem_a with ocimem_b coincident
  task automatic access(input int kind, input logic [7:0] a, input logic rd,
                        input logic [31:0] d, input int stalls, input int overrun_at);
    int  cyc;
    int  req_cyc;
    int  wrong_cyc;
    int  stall_left;
    int  exp_cyc;
    bit  busy;
    bit  is_read;
    bit  tmo;
    @(negedge clk);
    jdo = '0;
    case (kind)
      0, 3: begin
        jdo[34] = rd; jdo[17 +: 8] = a; take_a = 1'b1; take_b = (kind == 3);
        if (kind == 3) jdo[2:0] = 3'b101;
      end
      1: take_na = 1'b1;
      default: begin jdo[34:3] = d; take_b = 1'b1; end
    endcase
    busy    = (kind == 1) || (kind == 2) || rd;
    is_read = (kind != 2);
    tmo     = busy && (stalls >= int'(TIMEOUT));
    exp_cyc = !busy ? 0 : (tmo ? int'(TIMEOUT) : stalls + 1);
    if (kind == 0 || kind == 3) begin m_addr = a; m_err = 1'b0; end
    if (kind == 2) m_dreg = d;
    stall_left = stalls;
    bus.mem_waitrequest = 1'b0;
    @(negedge clk);
    take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
    if (busy) begin
      check("ready_low_when_busy", 32'(mon_ready), 32'd0);
      check("addr_during_access", 32'(bus.mem_address), 32'(m_addr));
    end
    cyc = 0; req_cyc = 0; wrong_cyc = 0;
    while ((bus.mem_read || bus.mem_write) && cyc < 40) begin
      cyc++;
      req_cyc++;
      if (is_read ? bus.mem_write : bus.mem_read) wrong_cyc++;
      take_b = (overrun_at != 0 && cyc == overrun_at);
      if (take_b) jdo = 38'($urandom);
      bus.mem_waitrequest = (stall_left > 0);
      bus.mem_readdata    = ram[bus.mem_address];
      if (!bus.mem_waitrequest && bus.mem_write) ram[bus.mem_address] = bus.mem_writedata;
      if (stall_left > 0) stall_left--;
      @(negedge clk);
    end
    take_b = 1'b0;
    bus.mem_waitrequest = 1'b0;
    if (busy && !tmo) begin
      if (is_read) m_dreg = m_ram[m_addr];
      else         m_ram[m_addr] = d;
      m_addr = m_addr + 8'd1;
    end
    if (tmo || overrun_at != 0) m_err = 1'b1;
    check("request_cycles", 32'(req_cyc), 32'(exp_cyc));
    check("wrong_request_cycles", 32'(wrong_cyc), 32'd0);
    check("address", 32'(bus.mem_address), 32'(m_addr));
    check("mondreg", mon_dreg, m_dreg);
    check("ready", 32'(mon_ready), 32'd1);
    check("error", 32'(mon_error), 32'(m_err));
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0; take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
    bus.mem_readdata = '0; bus.mem_waitrequest = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom; m_ram[i] = ram[i];
    end
    ram[8'h10] = 32'hCAFEF00D; m_ram[8'h10] = 32'hCAFEF00D;
    m_addr = '0; m_dreg = '0; m_err = 1'b0;

    #12;
    check("rst_address", 32'(bus.mem_address), 32'd0);
    check("rst_read", 32'(bus.mem_read), 32'd0);
    check("rst_write", 32'(bus.mem_write), 32'd0);
    check("rst_writedata", bus.mem_writedata, 32'd0);
    check("rst_mondreg", mon_dreg, 32'd0);
    check("rst_ready", 32'(mon_ready), 32'd1);
    check("rst_error", 32'(mon_error), 32'd0);
    reset_n = 1'b1;

    // Address load + zero-wait read.
    access(0, 8'h10, 1'b1, '0, 0, 0);
    check("read_cafef00d", mon_dreg, 32'hCAFEF00D);
    check("addr_after_read", 32'(bus.mem_address), 32'h11);
    // Write with 3 wait states, then read back.
    access(2, '0, 1'b0, 32'h12345678, 3, 0);
    access(0, 8'h11, 1'b1, '0, 0, 0);
    check("readback", mon_dreg, 32'h12345678);
    // Wrap at top of the address space.
    access(0, 8'hFF, 1'b0, '0, 0, 0);
    access(1, '0, 1'b0, '0, 0, 0);
    check("wrap_addr", 32'(bus.mem_address), 32'h00);
    // Timeout, then error cleared by an address load.
    access(1, '0, 1'b0, '0, 6, 0);
    check("timeout_error", 32'(mon_error), 32'd1);
    access(0, 8'h20, 1'b0, '0, 0, 0);
    check("error_cleared", 32'(mon_error), 32'd0);
    // Overrun: write strobe during a stalled read.
    access(1, '0, 1'b0, '0, 3, 2);
    // Coincident strobes: ocimem_a wins, ocimem_b dropped.
    access(3, 8'h40, 1'b0, '0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 2));
      access(k, 8'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 5)), 0);
    end

    // Asynchronous reset during a stalled write.
    @(negedge clk);
    jdo = '0; jdo[34:3] = 32'hDEADBEEF; take_b = 1'b1;
    @(negedge clk);
    take_b = 1'b0; bus.mem_waitrequest = 1'b1;
    @(negedge clk);
    check("pre_reset_write", 32'(bus.mem_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_write", 32'(bus.mem_write), 32'd0);
    check("async_rst_ready", 32'(mon_ready), 32'd1);
    check("async_rst_addr", 32'(bus.mem_address), 32'd0);
    check("async_rst_mondreg", mon_dreg, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; bus.mem_waitrequest = 1'b0;
    m_addr = '0; m_dreg = '0; m_err = 1'b0;
    access(1, '0, 1'b0, '0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sopc_2_cpu_jtag_mon_access.md
# sopc_2_cpu_jtag_mon_access

Debug-monitor memory access engine for the Nios II JTAG debug path. It sits directly downstream of the JTAG debug module's system-clock stage. It consumes the `jdo` payload and the `take_action_ocimem_*` / `take_no_action_ocimem_a` strobes, and runs single-word reads and writes on the CPU's on-chip debug RAM port. It returns `MonDReg`, `monitor_ready` and `monitor_error`, which the TCK-side capture logic shifts back to the host.

## Interface
- ADDR_W, 8, word-address width of the debug RAM; the address wraps modulo 2^ADDR_W
- TIMEOUT, 255, maximum consecutive wait-state cycles before an access is aborted (range 1..65535)

- clk  in  1  system clock
- reset_n  in  1  reset; one clock, reset asynchronous and active-low
- jdo  in  38  JTAG data payload, valid in the strobe cycle
- take_action_ocimem_a  in  1  one-cycle strobe: load address, optional read
- take_no_action_ocimem_a  in  1  one-cycle strobe: read at the current address
- take_action_ocimem_b  in  1  one-cycle strobe: write at the current address
- mem_readdata  in  32  RAM read data, valid when `mem_read`=1 and `mem_waitrequest`=0
- mem_waitrequest  in  1  RAM stall
- mem_address  out  ADDR_W  current word address
- mem_read  out  1  read request, held until accepted
- mem_write  out  1  write request, held until accepted
- mem_writedata  out  32  write data
- MonDReg  out  32  last read data, or last written data
- monitor_ready  out  1  engine idle and last result valid
- monitor_error  out  1  sticky error flag

## Operation
- The engine has three states: IDLE, RD, WR.
- Command decode happens in IDLE only.
  - `take_action_ocimem_a`:
    - Load `mem_address` from `jdo[17 +: ADDR_W]`.
    - Clear `monitor_error`.
    - If `jdo[34]`=1, go to RD; otherwise stay in IDLE with `monitor_ready` held at 1.
  - `take_no_action_ocimem_a`: go to RD at the current address.
  - `take_action_ocimem_b`:
    - Latch `jdo[34:3]` into `mem_writedata` and into `MonDReg`.
    - Go to WR.
- Priority when strobes coincide: ocimem_a, then no_action_ocimem_a, then ocimem_b. Lower-priority strobes are dropped silently.
- RD state:
  - `mem_read`=1.
  - On `mem_waitrequest`=0: capture `MonDReg` from `mem_readdata`, increment the address, return to IDLE.
- WR state:
  - `mem_write`=1.
  - On `mem_waitrequest`=0: increment the address, return to IDLE.
- Address increment wraps from 2^ADDR_W−1 to 0.
- Wait counter:
  - Counts cycles in RD/WR with `mem_waitrequest`=1. It clears on entry to RD/WR.
  - When the count reaches TIMEOUT: drop the request, return to IDLE, set `monitor_error`=1.
  - On a timeout, the address is not incremented and `MonDReg` is unchanged.
- Overrun: any strobe that arrives while in RD/WR is ignored and sets `monitor_error`=1. The access in progress continues.
- `monitor_error` clears only on `take_action_ocimem_a`. Its clear takes precedence over a same-cycle set, which cannot happen because IDLE and busy are exclusive.

## Timing
- Reset values:
  - state IDLE; `mem_address` 0; `mem_read` 0; `mem_write` 0.
  - `mem_writedata` 0; `MonDReg` 0.
  - `monitor_ready` 1; `monitor_error` 0; wait counter 0.
- All outputs are registered. There is no combinational path from input to output.
- Strobe at edge N:
  - From N+1, `mem_read`/`mem_write` is 1 and `monitor_ready` is 0.
  - `mem_address` and `mem_writedata` are valid from N+1.
- Access accepted at edge M (request=1, waitrequest=0):
  - From M+1, the request is 0, `monitor_ready` is 1, `MonDReg` is updated, and the address is +1.
  - Zero-wait latency is 2 cycles from strobe to ready.
- Timeout: the request is high for exactly TIMEOUT stalled cycles, then low. From the next cycle, `monitor_ready` is 1 and `monitor_error` is 1.
- Back-to-back: a strobe in the first cycle `monitor_ready` is 1 is accepted.
- Asynchronous reset mid-access: outputs return to reset values immediately, and the pending request is abandoned.

## Test plan
- Address load plus read: ocimem_a with address 0x10, `jdo[34]`=1, RAM[0x10]=0xCAFEF00D, no wait states.
  - `mem_read` high for 1 cycle at address 0x10.
  - `MonDReg`=0xCAFEF00D and `monitor_ready`=1 two cycles after the strobe.
  - Address becomes 0x11.
- Write then read-back: ocimem_b with `jdo[34:3]`=0x12345678 at address 0x11 and 3 wait states, then ocimem_a reload to 0x11 with read.
  - `mem_write` is high for 4 cycles.
  - Readback gives `MonDReg`=0x12345678.
- Wrap: address 0xFF, no_action_ocimem_a read.
  - Completes; address becomes 0x00.
- Timeout: TIMEOUT=4, `mem_waitrequest` stuck at 1, read issued.
  - `mem_read` is high for exactly 4 cycles.
  - `monitor_error`=1, `monitor_ready`=1, address and `MonDReg` unchanged.
  - A following ocimem_a clears `monitor_error`.
- Overrun: ocimem_b issued while a read is stalled.
  - The write is ignored (`mem_write` never asserts).
  - `monitor_error`=1; the read completes normally.
- Reset mid-access: `reset_n` pulled low during a stalled write.
  - `mem_write`=0 and `monitor_ready`=1 asynchronously.
  - Address is 0 after release.
